// File: rtl/uart_rx_fifo_if.sv
// Pop-side handshake between the UART receiver FIFO (slave) and the byte consumer (master).
// The head byte is offered on get_valid_ret/get_data_out_ret; tock_ready accepts it.
interface uart_rx_fifo_if;
  logic       tock_ready;
  logic       get_valid_ret;
  logic [7:0] get_data_out_ret;

  modport slave (
    input  tock_ready,
    output get_valid_ret,
    output get_data_out_ret
  );

  modport master (
    output tock_ready,
    input  get_valid_ret,
    input  get_data_out_ret
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with byte FIFO, running checksum and sticky error flags.
// Optional even-parity framing (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int cycles_per_bit = 3,
  parameter int fifo_depth     = 8
) (
  input  logic                        clock,
  input  logic                        tock_reset,
  input  logic                        tock_serial,
  uart_rx_fifo_if.slave               pop_if,
  output logic [$clog2(fifo_depth):0] get_count_ret,
  output logic [31:0]                 get_checksum_ret,
  output logic                        get_frame_err_ret,
  output logic                        get_overflow_ret,
  output logic                        get_parity_err_ret
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(cycles_per_bit);
  localparam logic [TW-1:0] TIMER_HALF = TW'((cycles_per_bit - 1) / 2);
  localparam logic [TW-1:0] TIMER_FULL = TW'(cycles_per_bit - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(fifo_depth);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  state_t          state_r;
  state_t          state_next_s;
  logic            serial_q_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            push_pend_r;
  logic            timing_s;
  logic            sample_s;
  logic            start_s;
  logic            shift_en_s;
  logic            push_req_s;
  logic            frame_err_set_s;
  logic            parity_err_set_s;
  logic            parity_bad_r;

  logic [7:0]      mem_r [fifo_depth];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     checksum_r;
  logic            frame_err_r;
  logic            overflow_r;
  logic            parity_err_r;
  logic            valid_r;
  logic [7:0]      data_r;

  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;
  logic            drop_s;
  logic [PW-1:0]   wr_ptr_next_s;
  logic [PW-1:0]   rd_ptr_next_s;
  logic [CW-1:0]   count_next_s;
  logic [7:0]      head_next_s;

  // Bit timer runs only while a frame is being sampled; sample fires as it reaches zero.
  always_comb begin
    timing_s = 1'b0;
    case (state_r)
      ST_START, ST_DATA, ST_STOP: timing_s = 1'b1;
`ifdef UART_RX_PARITY_EN
      ST_PARITY:                  timing_s = 1'b1;
`endif
      default:                    timing_s = 1'b0;
    endcase
    sample_s = timing_s & (timer_r == {TW{1'b0}});
  end

  // Frame state register.
  always_ff @(posedge clock) begin
    if (tock_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next_s     = state_r;
    start_s          = 1'b0;
    shift_en_s       = 1'b0;
    push_req_s       = 1'b0;
    frame_err_set_s  = 1'b0;
    parity_err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!serial_q_r) begin
          state_next_s = ST_START;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_s) begin
          if (serial_q_r) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_s) begin
          parity_err_set_s = (even_parity(shift_r) != serial_q_r);
          state_next_s     = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (sample_s) begin
          if (serial_q_r) begin
            push_req_s   = ~parity_bad_r;
            state_next_s = ST_IDLE;
          end else begin
            frame_err_set_s = 1'b1;
            state_next_s    = ST_BREAK;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (serial_q_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line synchroniser, bit timer, shifter and push request.
  always_ff @(posedge clock) begin
    if (tock_reset) begin
      serial_q_r   <= 1'b1;
      timer_r      <= {TW{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      push_pend_r  <= 1'b0;
      parity_bad_r <= 1'b0;
    end else begin
      serial_q_r  <= tock_serial;
      push_pend_r <= push_req_s;
      if (start_s) begin
        timer_r <= TIMER_HALF;
      end else if (sample_s) begin
        timer_r <= TIMER_FULL;
      end else if (timing_s) begin
        timer_r <= timer_r - 1'b1;
      end else begin
        timer_r <= timer_r;
      end
      if (start_s) begin
        bit_idx_r    <= 3'd0;
        parity_bad_r <= 1'b0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 1'b1;
        shift_r   <= {serial_q_r, shift_r[7:1]};
      end else begin
        bit_idx_r <= bit_idx_r;
        shift_r   <= shift_r;
      end
      if (parity_err_set_s) begin
        parity_bad_r <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping; the head is bypassed from the incoming byte when the FIFO was empty.
  always_comb begin
    pop_s     = valid_r & pop_if.tock_ready;
    full_s    = (count_r == COUNT_FULL);
    push_ok_s = push_pend_r & (~full_s | pop_s);
    drop_s    = push_pend_r & full_s & ~pop_s;
    if (push_ok_s) begin
      wr_ptr_next_s = wr_ptr_r + 1'b1;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = 8'h00;
    end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = shift_r;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Byte storage; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // Pointers, occupancy, checksum, sticky flags and registered pop-side outputs.
  always_ff @(posedge clock) begin
    if (tock_reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      checksum_r   <= 32'h0000_0000;
      frame_err_r  <= 1'b0;
      overflow_r   <= 1'b0;
      parity_err_r <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= 8'h00;
    end else begin
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      valid_r      <= (count_next_s != {CW{1'b0}});
      data_r       <= head_next_s;
      frame_err_r  <= frame_err_r | frame_err_set_s;
      overflow_r   <= overflow_r | drop_s;
      parity_err_r <= parity_err_r | parity_err_set_s;
      if (push_ok_s) begin
        checksum_r <= checksum_r + {24'h00_0000, shift_r};
      end else begin
        checksum_r <= checksum_r;
      end
    end
  end

  assign pop_if.get_valid_ret    = valid_r;
  assign pop_if.get_data_out_ret = data_r;
  assign get_count_ret           = count_r;
  assign get_checksum_ret        = checksum_r;
  assign get_frame_err_ret       = frame_err_r;
  assign get_overflow_ret        = overflow_r;
`ifdef UART_RX_PARITY_EN
  assign get_parity_err_ret      = parity_err_r;
`else
  assign get_parity_err_ret      = 1'b0;
  logic unused_parity_s;
  assign unused_parity_s = parity_err_r | parity_err_set_s;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial UART receiver: deserializes 8N1 frames from a single serial line and buffers accepted bytes in a small FIFO with a valid/ready pop interface.
- Sits at the receiving end of the link driven by the existing UART transmitter. It is the inbound half of uart_top-style loopback benches.
- Keeps a running 32-bit checksum of accepted bytes so benches can compare against the transmitter's message checksum.

Parameters:
cycles_per_bit, 3, clock cycles per serial bit (>=2).
fifo_depth, 8, FIFO entries; power of two, 2..64.

Ports:
clock  input  1  system clock; all state on posedge.
tock_reset  input  1  synchronous reset, active-high.
tock_serial  input  1  serial line, idle high.
tock_ready  input  1  consumer accepts head byte this cycle.
get_valid_ret  output  1  FIFO non-empty.
get_data_out_ret  output  8  FIFO head byte; 0 when empty.
get_count_ret  output  $clog2(fifo_depth)+1  current FIFO occupancy.
get_checksum_ret  output  32  wrapping sum of all bytes pushed into FIFO.
get_frame_err_ret  output  1  sticky: stop bit sampled low.
get_overflow_ret  output  1  sticky: byte dropped because FIFO full.
get_parity_err_ret  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clock`. Reset `tock_reset` is synchronous and active-high.
- Input register: serial_q registers tock_serial once; all decisions use serial_q. Reset value of serial_q is 1.
- Reset values: state=IDLE; timer, shifter, bit index, FIFO pointers, count and checksum all 0; all sticky flags 0; get_valid_ret=0, get_data_out_ret=0.
- Reset mid-frame: the partial byte is discarded; no push occurs.
- Timer:
  - Loaded with (cycles_per_bit-1)/2 when a start edge is detected.
  - Decrements each cycle. At 0 it asserts sample, then reloads cycles_per_bit-1.
- FSM:
  - IDLE: serial_q==0 -> START, load half timer.
  - START: on sample, serial_q==1 -> IDLE (glitch, ignored). Otherwise -> DATA, bit index=0.
  - DATA: on sample, shift serial_q in LSB-first. After bit index 7 -> STOP (PARITY if feature on).
  - STOP: on sample, serial_q==1 -> push byte, -> IDLE. serial_q==0 -> set frame_err, discard byte, -> BREAK.
  - BREAK: wait for serial_q==1 -> IDLE. A held-low line must not generate bytes.
- Push:
  - Occurs in the cycle after the stop-bit sample. The byte is visible on get_valid_ret/get_data_out_ret the following cycle.
  - Full and no pop in the same cycle: byte dropped, overflow set, checksum unchanged.
  - Full with a simultaneous pop: push succeeds and count stays at fifo_depth.
- Pop: get_valid_ret && tock_ready. tock_ready while empty is ignored.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, head advances.
- Wrap-around: pointers wrap modulo fifo_depth. Checksum wraps modulo 2^32 and adds only pushed bytes.
- Sticky flags clear only on reset.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - FSM inserts a PARITY state between DATA and STOP; one extra bit time per frame.
  - Even parity: parity bit = XOR of data bits.
  - Mismatch: set parity_err, still sample stop bit, discard the byte (no push, no checksum update). The framing rules above still apply.
- Undefined: no PARITY state; frames are 8N1; get_parity_err_ret is tied 0.

Test Plan:
- Frame 0x48 (start, bits LSB-first, stop; 3 cycles/bit) -> get_valid_ret=1, data=0x48, count=1, checksum=0x00000048. tock_ready=1 -> count=0, data=0.
- Stop bit driven 0 for byte 0xA5, then line high -> frame_err=1, count=0, checksum unchanged. Next frame 0x5A is received correctly.
- Line low for 1 cycle then high -> no byte, no error flags, FSM back in IDLE.
- 9 frames 0x01..0x09 with tock_ready=0, depth 8 -> count=8, overflow=1, checksum=0x24, head=0x01. Pop all 8 -> bytes 0x01..0x08 in order.
- FIFO full with tock_ready held 1 while 10th frame 0x0A completes -> push and pop same cycle, count stays 8, overflow not set, checksum=0x24+0x0A.
- tock_reset pulsed during DATA bit 4 -> all outputs at reset values next cycle. Subsequent frame 0x6C received with checksum=0x6C.
